// File: rtl/lcd_fetch_sched.sv
// Blink screen-fetch scheduler: walks one display row of attribute pairs into a FIFO,
// sharing the physical address bus with the Z80. Define LCD_FETCH_STARVE_EN for the starvation guard.
module lcd_fetch_sched #(
    parameter int LINE_CHARS   = 106,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        mck,
    input  logic        rin,
    input  logic [10:0] sbr,
    input  logic [2:0]  row,
    input  logic        line_start,
    input  logic        cpu_req,
    input  logic [21:0] cpu_ma,
    output logic        cpu_gnt,
    output logic [21:0] ma,
    output logic        fetch_oe_n,
    input  logic [7:0]  mdi,
    output logic [15:0] fifo_data,
    output logic        fifo_valid,
    input  logic        fifo_ready,
    output logic        busy,
    output logic        line_done,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [6:0]    LAST_CHAR = 7'(LINE_CHARS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, DONE} state_t;

    state_t        state;
    logic [2:0]    row_q;
    logic [6:0]    char_q;
    logic [7:0]    lo_byte;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          want;
    logic          dma_own;
    logic          force_slot;
    logic          push;
    logic          pop;

    // The count gate on FETCH_LO reserves room for the pair before its low byte is read.
    assign want       = (state == FETCH_LO && count < DEPTH_C) || (state == FETCH_HI);
    assign dma_own    = want & (~cpu_req | force_slot);
    assign cpu_gnt    = cpu_req & ~dma_own;
    assign ma         = dma_own ? {sbr, row_q, char_q, (state == FETCH_HI)} : cpu_ma;
    assign fetch_oe_n = ~dma_own;

    assign push       = dma_own && (state == FETCH_HI);
    assign pop        = fifo_valid & fifo_ready;
    assign fifo_valid = (count != '0);
    assign fifo_data  = fifo_mem[rd_ptr];

`ifdef LCD_FETCH_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

    assign starve_nxt = starve_cnt + 1'b1;

    // Counts consecutive denied fetch cycles; force_slot steals the next cycle from the CPU.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            starve_cnt <= '0;
            force_slot <= 1'b0;
        end else if (dma_own) begin
            starve_cnt <= '0;
            force_slot <= 1'b0;
        end else if (want && cpu_req && !force_slot) begin
            starve_cnt <= starve_nxt;
            force_slot <= (starve_nxt >= SW'(STARVE_LIMIT));
        end
    end
`else
    assign force_slot = 1'b0;
`endif

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            state     <= IDLE;
            busy      <= 1'b0;
            line_done <= 1'b0;
            row_q     <= '0;
            char_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    line_done <= 1'b0;
                    if (line_start) begin
                        row_q  <= row;
                        char_q <= '0;
                        busy   <= 1'b1;
                        state  <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (dma_own) state <= FETCH_HI;
                end
                FETCH_HI: begin
                    if (dma_own) begin
                        if (char_q == LAST_CHAR) begin
                            line_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            char_q <= char_q + 1'b1;
                            state  <= FETCH_LO;
                        end
                    end
                end
                DONE: begin
                    line_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new line_start during a row is recorded only; setting beats clearing.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            overrun <= 1'b0;
        end else if (line_start && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge mck) begin
        if (dma_own && state == FETCH_LO) lo_byte <= mdi;
        if (push) fifo_mem[wr_ptr] <= {mdi, lo_byte};
    end

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_fetch_sched.sv
// Directed bench for lcd_fetch_sched: free row, backpressure, CPU contention and stall,
// overrun flag behaviour and asynchronous reset mid-row.
module tb_lcd_fetch_sched;

    logic        mck;
    logic        rin;
    logic [10:0] sbr;
    logic [2:0]  row;
    logic        line_start;
    logic        cpu_req;
    logic [21:0] cpu_ma;
    logic        cpu_gnt;
    logic [21:0] ma;
    logic        fetch_oe_n;
    logic [7:0]  mdi;
    logic [15:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;
    logic        busy;
    logic        line_done;
    logic        overrun;
    logic        overrun_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_idx  = 0;

    lcd_fetch_sched dut (
        .mck(mck), .rin(rin), .sbr(sbr), .row(row), .line_start(line_start),
        .cpu_req(cpu_req), .cpu_ma(cpu_ma), .cpu_gnt(cpu_gnt), .ma(ma),
        .fetch_oe_n(fetch_oe_n), .mdi(mdi), .fifo_data(fifo_data),
        .fifo_valid(fifo_valid), .fifo_ready(fifo_ready), .busy(busy),
        .line_done(line_done), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    // Memory contents: every address returns a distinct-looking byte.
    function automatic logic [7:0] mem_byte(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [21:0] addr(input int c, input int b);
        logic [6:0] c7;
        logic       b1;
        c7 = c[6:0];
        b1 = b[0];
        return {sbr, row, c7, b1};
    endfunction

    function automatic logic [15:0] pair(input int c);
        return {mem_byte(addr(c, 1)), mem_byte(addr(c, 0))};
    endfunction

    assign mdi = mem_byte(ma);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then check popped data.
    task automatic cyc(input logic ls, input logic creq, input logic rdy, input logic ocl);
        @(negedge mck);
        line_start  = ls;
        cpu_req     = creq;
        fifo_ready  = rdy;
        overrun_clr = ocl;
        #1;
        if (fifo_valid && fifo_ready) begin
            chk($sformatf("pair%0d", pop_idx), fifo_data, pair(pop_idx));
            pop_idx++;
        end
    endtask

    task automatic drain(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            if (line_done) seen = 1'b1;
            if (seen && !busy && !fifo_valid) break;
        end
        chk("drain_line_done_seen", seen, 1'b1);
        chk("drain_pair_count", pop_idx, 106);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rin = 1'b1;
        sbr = 11'h400;
        row = 3'd3;
        line_start = 1'b0;
        cpu_req = 1'b1;
        cpu_ma = 22'h3ABCDE;
        fifo_ready = 1'b1;
        overrun_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge mck);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_line_done", line_done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_fifo_valid", fifo_valid, 1'b0);
        chk("rst_fetch_oe_n", fetch_oe_n, 1'b1);
        chk("rst_cpu_gnt_req1", cpu_gnt, 1'b1);
        chk("rst_ma", ma, 22'h3ABCDE);
        cpu_req = 1'b0;
        #1;
        chk("rst_cpu_gnt_req0", cpu_gnt, 1'b0);
        @(negedge mck);
        rin = 1'b0;

        // Free-running row, sbr=0x400 row=3
        pop_idx = 0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 214; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            if (k == 1) chk("free_first_ma", ma, 22'h200300);
            if (k == 2) chk("free_second_ma", ma, 22'h200301);
            if (k <= 212) begin
                chk($sformatf("free_oe_c%0d", k), fetch_oe_n, 1'b0);
                chk($sformatf("free_ma_c%0d", k), ma, addr((k - 1) / 2, (k - 1) % 2));
            end
            chk($sformatf("free_line_done_c%0d", k), line_done, (k == 213));
            chk($sformatf("free_busy_c%0d", k), busy, (k <= 213));
        end
        chk("free_pair_count", pop_idx, 106);
        chk("free_fifo_empty", fifo_valid, 1'b0);

        // FIFO backpressure, row=5
        sbr = 11'h155;
        row = 3'd5;
        pop_idx = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("bp_fetch_c%0d", k), fetch_oe_n, 1'b0);
        end
        for (int k = 9; k <= 14; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("bp_stall_oe_c%0d", k), fetch_oe_n, 1'b1);
            chk($sformatf("bp_stall_ma_c%0d", k), ma, 22'h3ABCDE);
            chk($sformatf("bp_busy_c%0d", k), busy, 1'b1);
        end
        chk("bp_head_valid", fifo_valid, 1'b1);
        chk("bp_head_data", fifo_data, pair(0));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_resume_full_oe", fetch_oe_n, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_resume_oe", fetch_oe_n, 1'b0);
        chk("bp_resume_ma_char4", ma, addr(4, 0));
        drain(400);

        // CPU contention and stall mid-pair
        sbr = 11'h2A7;
        row = 3'd1;
        pop_idx = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("cont_idle_gnt", cpu_gnt, 1'b1);
`ifdef LCD_FETCH_STARVE_EN
        for (int k = 1; k <= 18; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("starve_oe_c%0d", k), fetch_oe_n, !(k == 9 || k == 18));
            chk($sformatf("starve_gnt_c%0d", k), cpu_gnt, !(k == 9 || k == 18));
            if (k == 9)  chk("starve_ma_lo", ma, addr(0, 0));
            if (k == 18) chk("starve_ma_hi", ma, addr(0, 1));
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("starve_pair0_popped", pop_idx, 1);
`else
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("cont_oe_c%0d", k), fetch_oe_n, 1'b1);
            chk($sformatf("cont_gnt_c%0d", k), cpu_gnt, 1'b1);
            chk($sformatf("cont_ma_c%0d", k), ma, 22'h3ABCDE);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("cont_free_oe", fetch_oe_n, 1'b0);
        chk("cont_free_gnt", cpu_gnt, 1'b0);
        chk("cont_free_ma_lo", ma, addr(0, 0));
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("stall_hi_oe_%0d", k), fetch_oe_n, 1'b1);
            chk($sformatf("stall_hi_gnt_%0d", k), cpu_gnt, 1'b1);
            chk($sformatf("stall_hi_valid_%0d", k), fifo_valid, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_hi_resume_oe", fetch_oe_n, 1'b0);
        chk("stall_hi_resume_ma", ma, addr(0, 1));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_pair0_popped", pop_idx, 1);
        chk("stall_next_ma", ma, addr(1, 0));
`endif
        drain(400);

        // Overrun while busy
        sbr = 11'h400;
        row = 3'd3;
        pop_idx = 0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 100; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_before", overrun, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovr_char50_ma", ma, addr(50, 0));
        chk("ovr_not_yet", overrun, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_row_continues", ma, addr(50, 1));
        drain(400);
        chk("ovr_sticky", overrun, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_clr_same_cycle", overrun, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_cleared", overrun, 1'b0);

        // line_start in IDLE, then clear colliding with a set, then async reset
        row = 3'd6;
        pop_idx = 0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_start_no_ovr", overrun, 1'b0);
        chk("idle_start_busy", busy, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_set_wins", overrun, 1'b1);
        chk("pre_rst_valid", fifo_valid, 1'b1);
        chk("pre_rst_head", fifo_data, pair(0));
        chk("pre_rst_oe", fetch_oe_n, 1'b0);
        chk("pre_rst_ma", ma, addr(1, 1));
        #2;
        rin = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_fifo_valid", fifo_valid, 1'b0);
        chk("arst_oe", fetch_oe_n, 1'b1);
        chk("arst_ma", ma, 22'h3ABCDE);
        chk("arst_overrun", overrun, 1'b0);
        @(negedge mck);
        rin = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", fifo_valid, 1'b0);
        chk("post_rst_line_done", line_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
